// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode values, sequencer state encoding,
// opcode classes and PC-select encodings.
package core_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_MEM     = 3'd4,
        ST_WB      = 3'd5,
        ST_TRAP    = 3'd6
    } state_e;

    // CLS_NONE doubles as the cleared/illegal class value.
    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_R      = 4'd1,
        CLS_IALU   = 4'd2,
        CLS_LOAD   = 4'd3,
        CLS_STORE  = 4'd4,
        CLS_BRANCH = 4'd5,
        CLS_LUI    = 4'd6,
        CLS_AUIPC  = 4'd7,
        CLS_JAL    = 4'd8,
        CLS_JALR   = 4'd9
    } op_class_e;

    localparam logic [1:0] PCSEL_PC4    = 2'd0;
    localparam logic [1:0] PCSEL_PCIMM  = 2'd1;
    localparam logic [1:0] PCSEL_RS1IMM = 2'd2;

    function automatic logic is_mem_class(input op_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/op_classify.sv
// Combinational opcode-to-class mapping with an illegal-opcode flag.
module op_classify
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    output op_class_e  class_o,
    output logic       illegal_o
);

    always_comb begin
        class_o   = CLS_NONE;
        illegal_o = 1'b0;
        case (opcode_i)
            OP_R:      class_o = CLS_R;
            OP_IALU:   class_o = CLS_IALU;
            OP_LOAD:   class_o = CLS_LOAD;
            OP_STORE:  class_o = CLS_STORE;
            OP_BRANCH: class_o = CLS_BRANCH;
            OP_LUI:    class_o = CLS_LUI;
            OP_AUIPC:  class_o = CLS_AUIPC;
            OP_JAL:    class_o = CLS_JAL;
            OP_JALR:   class_o = CLS_JALR;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/mem/write-back FSM with
// memory handshakes, per-cycle enables and a retired-instruction counter.
module cpu_sequencer
    import core_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             iClk,
    input  logic             iRstN,
    input  logic [6:0]       iOpcode,
    input  logic             iBranchTaken,
    input  logic             iIMemReady,
    input  logic             iDMemReady,
    output logic             oIMemReq,
    output logic             oIrWrite,
    output logic             oDMemReq,
    output logic             oDMemWe,
    output logic             oRegWrite,
    output logic             oPcWrite,
    output logic [1:0]       oPcSel,
    output logic             oRetire,
    output logic             oTrap,
    output logic [2:0]       oState,
    output logic [CNT_W-1:0] oInstret
);

    state_e           state_q, state_d;
    op_class_e        class_q, class_d;
    logic [CNT_W-1:0] instret_q;

    op_class_e dec_class;
    logic      dec_illegal;

    op_classify u_classify (
        .opcode_i  (iOpcode),
        .class_o   (dec_class),
        .illegal_o (dec_illegal)
    );

    // Enables depend only on the registered state/class plus the ready or
    // branch input of the current cycle; iOpcode only feeds class_d.
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        oIMemReq  = 1'b0;
        oIrWrite  = 1'b0;
        oDMemReq  = 1'b0;
        oDMemWe   = 1'b0;
        oRegWrite = 1'b0;
        oPcWrite  = 1'b0;
        oPcSel    = PCSEL_PC4;
        oRetire   = 1'b0;
        oTrap     = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                oIMemReq = 1'b1;
                if (iIMemReady) begin
                    oIrWrite = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                class_d = dec_class;
                state_d = dec_illegal ? ST_TRAP : ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (class_q == CLS_BRANCH) begin
                    oPcWrite = 1'b1;
                    oRetire  = 1'b1;
                    oPcSel   = iBranchTaken ? PCSEL_PCIMM : PCSEL_PC4;
                    state_d  = ST_FETCH;
                end else if (is_mem_class(class_q)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                oDMemReq = 1'b1;
                oDMemWe  = (class_q == CLS_STORE);
                if (iDMemReady) begin
                    if (class_q == CLS_STORE) begin
                        oPcWrite = 1'b1;
                        oRetire  = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                oRegWrite = 1'b1;
                oPcWrite  = 1'b1;
                oRetire   = 1'b1;
                state_d   = ST_FETCH;
                case (class_q)
                    CLS_JAL:  oPcSel = PCSEL_PCIMM;
                    CLS_JALR: oPcSel = PCSEL_RS1IMM;
                    default:  oPcSel = PCSEL_PC4;
                endcase
            end
            ST_TRAP: oTrap = 1'b1;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_NONE;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            if (oRetire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign oState   = state_q;
    assign oInstret = instret_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle sequencing FSM for the RV32I core. It steps each instruction through fetch, decode, execute, memory and write-back, and handshakes with the instruction and data memories. It gates the static opcode decode flags into per-cycle enables (PC, IR, register file, memory) and counts retired instructions. It sits between the instruction register's opcode field, the ALU branch-compare result and the two memory ports.

## Interface
Parameters:
- CNT_W, 32, width of the retired-instruction counter

Ports:
- iClk  in  1  core clock
- iRstN  in  1  asynchronous, active-low reset
- iOpcode  in  7  instr[6:0] from instruction register; valid from DECODE onward
- iBranchTaken  in  1  ALU compare result; valid in EXECUTE
- iIMemReady  in  1  instruction memory accepted request and returned data this cycle
- iDMemReady  in  1  data memory completed access this cycle
- oIMemReq  out  1  instruction fetch request
- oIrWrite  out  1  load instruction register
- oDMemReq  out  1  data memory request
- oDMemWe  out  1  data request is a write (qualifies oDMemReq)
- oRegWrite  out  1  register file write enable
- oPcWrite  out  1  PC update enable
- oPcSel  out  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = rs1+imm (JALR)
- oRetire  out  1  one-cycle pulse per completed instruction
- oTrap  out  1  sticky illegal-opcode indication
- oState  out  3  current state encoding, for debug
- oInstret  out  CNT_W  retired-instruction count

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
- Opcode classes: R, I-ALU, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR. Any other value is ILLEGAL.
- IDLE: reset state. Moves unconditionally to FETCH on the next clock.
- FETCH:
  - oIMemReq=1 every cycle until iIMemReady.
  - In the iIMemReady cycle: oIrWrite=1, next state DECODE.
- DECODE:
  - Class of iOpcode latched into an internal class register. Later states use only the latched class.
  - ILLEGAL goes to TRAP; all other classes go to EXECUTE.
- EXECUTE:
  - BRANCH retires here: oPcWrite=1, oPcSel=iBranchTaken?1:0, oRetire=1, next state FETCH.
  - LOAD and STORE go to MEM.
  - All other classes go to WB.
- MEM:
  - oDMemReq=1 and oDMemWe=(class==STORE), held until iDMemReady.
  - On iDMemReady: LOAD goes to WB.
  - On iDMemReady: STORE retires with oPcWrite=1, oPcSel=0, oRetire=1, next state FETCH.
- WB:
  - oRegWrite=1, oPcWrite=1, oRetire=1, next state FETCH.
  - oPcSel: 1 for JAL, 2 for JALR, 0 otherwise.
- TRAP: oTrap=1. No requests or writes are issued. Only reset leaves TRAP.
- oInstret increments by 1 on every oRetire cycle and wraps modulo 2^CNT_W.

## Timing
- Reset (iRstN low, asynchronous) forces:
  - state=IDLE, class register cleared, oInstret=0.
  - All outputs 0; oState=IDLE encoding.
  - Reset asserted mid-instruction abandons the instruction immediately: no retire, no partial write. Outstanding memory requests drop the same cycle.
- All enables are Moore outputs of the registered state, plus the same-cycle ready input where a transition depends on it. They contain no combinational path from iOpcode.
- Instruction latency with zero-wait memory (iIMemReady and iDMemReady high on the first request cycle):
  - BRANCH: 3 cycles.
  - R, I-ALU, LUI, AUIPC, JAL, JALR, STORE: 4 cycles.
  - LOAD: 5 cycles.
- Each memory wait cycle adds exactly one cycle.
- Memory handshakes:
  - A request stays asserted with stable oDMemWe until ready.
  - iIMemReady is ignored outside FETCH; iDMemReady is ignored outside MEM.
- Exactly one oRetire per instruction. oRetire and oPcWrite always coincide.
- oInstret shows the incremented value in the cycle after oRetire.

## Structure
- Shared package core_pkg holds:
  - the opcode localparams (7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111);
  - the state encoding and the oPcSel encodings.
- One sub-module, op_classify: a combinational mapping from iOpcode to class plus an illegal flag. It is reused by the decode logic.
- The FSM, class register and instret counter live in cpu_sequencer.

## Test plan
- Reset release, iIMemReady=1, iOpcode=0110011 -> states IDLE, FETCH, DECODE, EXECUTE, WB; oRegWrite and oRetire high in WB; oInstret=1 the next cycle.
- LOAD (0000011) with iDMemReady low for 3 MEM cycles -> oDMemReq=1, oDMemWe=0 for 4 cycles, then WB with oRegWrite=1; total 8 cycles.
- STORE (0100011), zero wait -> oDMemWe=1 in MEM; retire in MEM with oRegWrite=0, oPcSel=0.
- BRANCH with iBranchTaken=1, then a second BRANCH with iBranchTaken=0 -> retire in EXECUTE with oPcSel=1, then oPcSel=0; oRegWrite never asserted.
- iOpcode=7'b1111111 -> TRAP after DECODE; oTrap=1 held for 20 cycles with no requests; iRstN pulse returns the block to IDLE with oTrap=0.
- iRstN asserted during a MEM wait -> oDMemReq drops immediately; no retire; oInstret=0; the next fetch starts 2 cycles after release.
